// File: rtl/dqn_ctrl_pkg.sv
// Shared phase codes, FSM state type and step width for the DQN training control path.
package dqn_ctrl_pkg;

  localparam int unsigned STEP_W = 4;
  localparam int unsigned PH_W   = 4;

  localparam logic [PH_W-1:0] PH_IDLE = 4'd0;
  localparam logic [PH_W-1:0] PH_FWD  = 4'd1;
  localparam logic [PH_W-1:0] PH_BWD  = 4'd2;
  localparam logic [PH_W-1:0] PH_UPD  = 4'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFwd,
    StBwd,
    StUpd,
    StFin
  } state_e;

  function automatic logic [PH_W-1:0] phase_code(state_e s);
    logic [PH_W-1:0] code;
    unique case (s)
      StFwd:   code = PH_FWD;
      StBwd:   code = PH_BWD;
      StUpd:   code = PH_UPD;
      default: code = PH_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags the cycle in which a phase has run TIMEOUT_CYC cycles.
module phase_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed cycles of the phase, so the current cycle is cnt_q + 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntW'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign expired_o = enable_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dqn_phase_sequencer.sv
// Episode/step/phase controller driving the shared step and controller buses.
module dqn_phase_sequencer
  import dqn_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STEP    = 15,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] num_steps_i,
  input  logic              fwd_done_i,
  input  logic              bwd_done_i,
  input  logic              upd_done_i,
  output logic [STEP_W-1:0] step_o,
  output logic [PH_W-1:0]   controller_o,
  output logic              phase_start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_err_o
);

  localparam logic [STEP_W-1:0] MaxStepL = STEP_W'(MAX_STEP);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] nsteps_q, nsteps_d;
  logic [PH_W-1:0]   ctrl_q, ctrl_d;
  logic              phase_start_q, phase_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic phase_done;
  logic in_phase;
  logic expired;
  logic start_ok;

  assign start_ok = start_i && (num_steps_i != '0) && (num_steps_i <= MaxStepL);
  assign in_phase = (state_q == StFwd) || (state_q == StBwd) || (state_q == StUpd);

  always_comb begin
    phase_done = 1'b0;
    unique case (state_q)
      StFwd:   phase_done = fwd_done_i;
      StBwd:   phase_done = bwd_done_i;
      StUpd:   phase_done = upd_done_i;
      default: phase_done = 1'b0;
    endcase
  end

  phase_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (phase_start_d),
    .enable_i  (in_phase),
    .expired_o (expired)
  );

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    nsteps_d      = nsteps_q;
    err_d         = err_q;
    done_d        = 1'b0;
    phase_start_d = 1'b0;

    if (abort_i) begin
      state_d = StIdle;
      step_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_d       = StFwd;
            step_d        = STEP_W'(1);
            nsteps_d      = num_steps_i;
            err_d         = 1'b0;
            phase_start_d = 1'b1;
          end
        end
        StFwd, StBwd, StUpd: begin
          // A done arriving in the expiry cycle still wins over the watchdog.
          if (phase_done) begin
            phase_start_d = 1'b1;
            if (state_q == StFwd) begin
              state_d = StBwd;
            end else if (state_q == StBwd) begin
              state_d = StUpd;
            end else if (step_q == nsteps_q) begin
              state_d       = StFin;
              step_d        = '0;
              done_d        = 1'b1;
              phase_start_d = 1'b0;
            end else begin
              state_d = StFwd;
              step_d  = step_q + STEP_W'(1);
            end
          end else if (expired) begin
            state_d = StIdle;
            step_d  = '0;
            err_d   = 1'b1;
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          step_d  = '0;
        end
      endcase
    end

    ctrl_d = phase_code(state_d);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      step_q        <= '0;
      nsteps_q      <= '0;
      ctrl_q        <= PH_IDLE;
      phase_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      nsteps_q      <= nsteps_d;
      ctrl_q        <= ctrl_d;
      phase_start_q <= phase_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign step_o        = step_q;
  assign controller_o  = ctrl_q;
  assign phase_start_o = phase_start_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_dqn_phase_sequencer.sv
// Bench for dqn_phase_sequencer: hand tables, directed corner cases and a random run vs. a model.
module tb_dqn_phase_sequencer;

  localparam int unsigned TO = 4;
  localparam int unsigned MS = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] num_steps;
  logic       fwd_done, bwd_done, upd_done;
  logic [3:0] step;
  logic [3:0] controller;
  logic       phase_start, busy, done, timeout_err;

  always #5 clk = ~clk;

  dqn_phase_sequencer #(
    .MAX_STEP    (MS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .num_steps_i   (num_steps),
    .fwd_done_i    (fwd_done),
    .bwd_done_i    (bwd_done),
    .upd_done_i    (upd_done),
    .step_o        (step),
    .controller_o  (controller),
    .phase_start_o (phase_start),
    .busy_o        (busy),
    .done_o        (done),
    .timeout_err_o (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase index 0 = idle, 1..3 = fwd/bwd/upd; fin is a separate flag.
  int m_ph, m_step, m_n, m_age;
  bit m_fin, m_err, m_ps, m_done;

  task automatic model_reset();
    m_ph = 0; m_step = 0; m_n = 0; m_age = 0;
    m_fin = 0; m_err = 0; m_ps = 0; m_done = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input int n,
                            input bit f, input bit b, input bit u);
    bit pd;
    m_ps = 0;
    m_done = 0;
    if (a) begin
      m_ph = 0; m_fin = 0; m_step = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_ph == 0) begin
      if (s && n >= 1 && n <= MS) begin
        m_ph = 1; m_step = 1; m_n = n; m_err = 0; m_age = 0; m_ps = 1;
      end
    end else begin
      m_age++;
      pd = (m_ph == 1) ? f : (m_ph == 2) ? b : u;
      if (pd) begin
        if (m_ph < 3) begin
          m_ph++; m_age = 0; m_ps = 1;
        end else if (m_step == m_n) begin
          m_ph = 0; m_fin = 1; m_step = 0; m_done = 1;
        end else begin
          m_step++; m_ph = 1; m_age = 0; m_ps = 1;
        end
      end else if (m_age >= TO) begin
        m_err = 1; m_ph = 0; m_step = 0;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " ctrl"}, int'(controller), m_fin ? 0 : m_ph);
    chk({tag, " step"}, int'(step), m_step);
    chk({tag, " phase_start"}, int'(phase_start), int'(m_ps));
    chk({tag, " busy"}, int'(busy), (m_ph != 0 || m_fin) ? 1 : 0);
    chk({tag, " done"}, int'(done), int'(m_done));
    chk({tag, " timeout_err"}, int'(timeout_err), int'(m_err));
  endtask

  task automatic tick(input string tag, input bit s, input bit a, input int n,
                      input bit f, input bit b, input bit u);
    start = s; abort = a; num_steps = 4'(n);
    fwd_done = f; bwd_done = b; upd_done = u;
    model_step(s, a, n, f, b, u);
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctrl"}, int'(controller), 0);
    chk({tag, " step"}, int'(step), 0);
    chk({tag, " phase_start"}, int'(phase_start), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " timeout_err"}, int'(timeout_err), 0);
  endtask

  typedef struct {
    bit s, a; int n; bit f, b, u;
    int e_ctrl, e_step; bit e_ps, e_busy, e_done, e_err;
  } vec_t;

  vec_t vt[9];

  initial begin
    int ps_cnt, done_cnt, bwd_cycles;

    // Zero-wait table: num_steps=0 is ignored, then a 2-step episode with all dones high.
    vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 2, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    vt[2] = '{0, 0, 2, 1, 1, 1, 2, 1, 1, 1, 0, 0};
    vt[3] = '{0, 0, 2, 1, 1, 1, 3, 1, 1, 1, 0, 0};
    vt[4] = '{0, 0, 2, 1, 1, 1, 1, 2, 1, 1, 0, 0};
    vt[5] = '{0, 0, 2, 1, 1, 1, 2, 2, 1, 1, 0, 0};
    vt[6] = '{0, 0, 2, 1, 1, 1, 3, 2, 1, 1, 0, 0};
    vt[7] = '{0, 0, 2, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    vt[8] = '{0, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    start = 0; abort = 0; num_steps = 0; fwd_done = 0; bwd_done = 0; upd_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tick("tbl", vt[i].s, vt[i].a, vt[i].n, vt[i].f, vt[i].b, vt[i].u);
      chk($sformatf("tbl%0d ctrl", i), int'(controller), vt[i].e_ctrl);
      chk($sformatf("tbl%0d step", i), int'(step), vt[i].e_step);
      chk($sformatf("tbl%0d ps", i), int'(phase_start), int'(vt[i].e_ps));
      chk($sformatf("tbl%0d busy", i), int'(busy), int'(vt[i].e_busy));
      chk($sformatf("tbl%0d done", i), int'(done), int'(vt[i].e_done));
    end

    // Nominal 3-step episode, each done raised in the second cycle of its phase.
    ps_cnt = 0;
    done_cnt = 0;
    tick("nom start", 1, 0, 3, 0, 0, 0);
    ps_cnt += int'(phase_start);
    for (int s = 1; s <= 3; s++) begin
      for (int p = 1; p <= 3; p++) begin
        tick("nom wait", 0, 0, 3, 0, 0, 0);
        chk($sformatf("nom s%0d p%0d ctrl", s, p), int'(controller), p);
        chk($sformatf("nom s%0d p%0d step", s, p), int'(step), s);
        ps_cnt += int'(phase_start);
        done_cnt += int'(done);
        tick("nom done", 0, 0, 3, p == 1, p == 2, p == 3);
        ps_cnt += int'(phase_start);
        done_cnt += int'(done);
      end
    end
    tick("nom tail", 0, 0, 3, 0, 0, 0);
    done_cnt += int'(done);
    chk("nom phase_start count", ps_cnt, 9);
    chk("nom done count", done_cnt, 1);
    chk("nom busy after", int'(busy), 0);

    // Stray handshakes during FWD.
    tick("stray start", 1, 0, 2, 0, 0, 0);
    tick("stray upd", 0, 0, 2, 0, 0, 1);
    chk("stray upd ctrl", int'(controller), 1);
    tick("stray bwd", 0, 0, 2, 0, 1, 0);
    chk("stray bwd ctrl", int'(controller), 1);
    tick("stray fwd", 0, 0, 2, 1, 0, 0);
    chk("stray fwd ctrl", int'(controller), 2);
    tick("stray abort", 0, 1, 2, 0, 0, 0);

    // Watchdog: BWD without bwd_done lasts TO cycles, then error and IDLE.
    tick("wd start", 1, 0, 1, 0, 0, 0);
    tick("wd fwd", 0, 0, 1, 1, 0, 0);
    bwd_cycles = (controller == 4'd2) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick("wd wait", 0, 0, 1, 0, 0, 0);
      if (controller == 4'd2) bwd_cycles++;
      else break;
    end
    chk("wd bwd cycles", bwd_cycles, TO);
    chk("wd err set", int'(timeout_err), 1);
    chk("wd busy", int'(busy), 0);
    tick("wd restart", 1, 0, 1, 0, 0, 0);
    chk("wd err cleared", int'(timeout_err), 0);
    chk("wd restart ctrl", int'(controller), 1);
    tick("wd abort", 0, 1, 1, 0, 0, 0);

    // Abort beats upd_done on the last step.
    tick("ab start", 1, 0, 1, 0, 0, 0);
    tick("ab fwd", 0, 0, 1, 1, 0, 0);
    tick("ab bwd", 0, 0, 1, 0, 1, 0);
    tick("ab both", 0, 1, 1, 0, 0, 1);
    chk("ab ctrl", int'(controller), 0);
    chk("ab step", int'(step), 0);
    chk("ab done", int'(done), 0);
    chk("ab busy", int'(busy), 0);

    // Asynchronous reset in the middle of FWD.
    tick("rst start", 1, 0, 2, 0, 0, 0);
    start = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick("rst after", 0, 0, 2, 1, 1, 1);
    chk("rst no resume", int'(busy), 0);

    for (int i = 0; i < 2000; i++) begin
      tick("rand", ($urandom % 6) == 0, ($urandom % 64) == 0, int'($urandom % 16),
           ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
